// File: rtl/ahb_defs.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_defs (package)
//  Description : Shared AHB-Lite encodings and FSM state type for the
//                single-port word memory slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_defs;

    // HTRANS transfer type codes
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Only 32-bit word transfers are supported
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // HRESP codes
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Slave transfer FSM
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // True for HTRANS values that request a real transfer (NONSEQ/SEQ)
    function automatic logic trans_active(input logic [1:0] i_trans);
        logic v;
        case (i_trans)
            HTRANS_NONSEQ, HTRANS_SEQ: v = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  v = 1'b0;
            default:                   v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem_array
//  Description : DEPTH x 32-bit storage, one synchronous write port and one
//                asynchronous read port. Not reset: contents survive HRESETN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write port: commit on the rising edge when enabled
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port is combinational so a DATA-phase read sees the latest write
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem
//  Description : AHB-Lite slave backed by a DEPTH-word memory. Inserts
//                WAIT_STATES wait cycles per OKAY transfer, answers illegal
//                size/alignment/range with a two-cycle ERROR response, and
//                pipelines a new address phase out of DATA or ERR2.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mem
    import ahb_defs::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_hclk,
    input  logic        i_hresetn,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic        o_hresp,
    output logic [31:0] o_hrdata
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [31:0] c_WIN_MASK = ~((32'(DEPTH) * 32'd4) - 32'd1);
    localparam logic [3:0]  c_WS       = 4'(WAIT_STATES);

    state_t            r_state;
    logic [3:0]        r_count;
    logic [c_AW-1:0]   r_index;
    logic              r_write;
    logic              r_hreadyout;
    logic              r_hresp;

    logic              w_accept;
    logic              w_legal;
    logic [c_AW-1:0]   w_index;
    logic              w_we;
    logic              w_is_read;
    logic [31:0]       w_rdata;
    logic              w_unused_ok;

    // Bursts are treated beat by beat, so HBURST carries no information here
    assign w_unused_ok = ^i_hburst;

    // Address phase qualification and legality of the presented transfer
    assign w_accept  = i_hsel & i_hready & trans_active(i_htrans);
    assign w_legal   = (i_hsize == HSIZE_WORD) &&
                       (i_haddr[1:0] == 2'b00) &&
                       ((i_haddr & c_WIN_MASK) == BASE_ADDR);
    assign w_index   = i_haddr[c_AW+1:2];

    // Data phase controls: write commits on the edge closing DATA
    assign w_we      = (r_state == ST_DATA) &&  r_write;
    assign w_is_read = (r_state == ST_DATA) && !r_write;

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_hrdata    = w_is_read ? w_rdata : 32'd0;

    // Transfer FSM with registered HREADYOUT/HRESP
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state     <= ST_IDLE;
            r_count     <= 4'd0;
            r_index     <= '0;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    // Count reaches one on the last low cycle
                    if (r_count <= 4'd1) begin
                        r_state     <= ST_DATA;
                        r_count     <= 4'd0;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end else begin
                        r_count     <= r_count - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 all close with HREADYOUT high and
                    // may take the next address phase without a bubble
                    if (w_accept) begin
                        r_index <= w_index;
                        r_write <= i_hwrite;
                        if (!w_legal) begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else if (c_WS != 4'd0) begin
                            r_state     <= ST_WAIT;
                            r_count     <= c_WS;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_OKAY;
                        end else begin
                            r_state     <= ST_DATA;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= HRESP_OKAY;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    ahb_slave_mem_array #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_array (
        .i_clk   (i_hclk),
        .i_we    (w_we),
        .i_waddr (r_index),
        .i_wdata (i_hwdata),
        .i_raddr (r_index),
        .o_rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_slave_mem
//  Description : Self-checking bench for ahb_slave_mem. Three instances with
//                WAIT_STATES = 1, 0 and 3 share one clock; each is driven in
//                turn from a command queue with a scoreboard of expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem;

    typedef struct {
        bit          hsel;
        logic [1:0]  htrans;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        bit          err;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    localparam int c_BUDGET = 400;

    logic        clk = 1'b0;
    logic        rstn   [3];
    logic        hsel   [3];
    logic [31:0] haddr  [3];
    logic [1:0]  htrans [3];
    logic        hwrite [3];
    logic [2:0]  hsize  [3];
    logic [31:0] hwdata [3];
    logic        hreadyout [3];
    logic        hresp  [3];
    logic [31:0] hrdata [3];

    logic [31:0] mdl [3][64];
    cmd_t        cmd_q [$];
    exp_t        sb_q  [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_slave_mem #(
            .DEPTH       (64),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .i_hclk      (clk),
            .i_hresetn   (rstn[g]),
            .i_hsel      (hsel[g]),
            .i_haddr     (haddr[g]),
            .i_htrans    (htrans[g]),
            .i_hwrite    (hwrite[g]),
            .i_hsize     (hsize[g]),
            .i_hburst    (3'b000),
            .i_hwdata    (hwdata[g]),
            .i_hready    (hreadyout[g]),
            .o_hreadyout (hreadyout[g]),
            .o_hresp     (hresp[g]),
            .o_hrdata    (hrdata[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add(input bit s, input logic [1:0] t, input bit w,
                       input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        cmd_t c;
        c.hsel = s; c.htrans = t; c.write = w; c.addr = a; c.size = sz; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    // Expected outcome of one command, updating the memory model in order
    task automatic predict(input int k, input cmd_t c, output exp_t e);
        e.wdata = c.wdata; e.err = 1'b0; e.waits = 0; e.rdata = 32'd0;
        if (c.hsel && c.htrans[1]) begin
            if (c.size == 3'b010 && c.addr[1:0] == 2'b00 && c.addr < 32'h100) begin
                e.waits = ws_of(k);
                if (c.write) mdl[k][c.addr[7:2]] = c.wdata;
                else         e.rdata = mdl[k][c.addr[7:2]];
            end else begin
                e.err = 1'b1; e.waits = 1;
            end
        end
    endtask

    // Issue queued commands to instance k back-to-back and check each data phase
    task automatic run(input int k);
        cmd_t c;
        exp_t e;
        exp_t cur;
        int   waits;
        int   budget;
        bit   dp;
        dp = 1'b0; waits = 0; budget = 0;
        while ((cmd_q.size() > 0 || dp) && budget < c_BUDGET) begin
            @(negedge clk);
            budget++;
            if (dp) begin
                cur = sb_q[0];
                hwdata[k] = cur.wdata;
                chk($sformatf("i%0d_hresp", k), {31'd0, hresp[k]}, {31'd0, cur.err});
                if (hreadyout[k]) begin
                    chk($sformatf("i%0d_waits", k), 32'(waits), 32'(cur.waits));
                    chk($sformatf("i%0d_hrdata", k), hrdata[k], cur.rdata);
                    void'(sb_q.pop_front());
                    dp = 1'b0;
                end else begin
                    waits++;
                    chk($sformatf("i%0d_hrdata_low", k), hrdata[k], 32'd0);
                end
            end
            if (hreadyout[k]) begin
                if (cmd_q.size() > 0) begin
                    c = cmd_q.pop_front();
                    hsel[k] = c.hsel; htrans[k] = c.htrans; hwrite[k] = c.write;
                    haddr[k] = c.addr; hsize[k] = c.size;
                    predict(k, c, e);
                    sb_q.push_back(e);
                    dp = 1'b1; waits = 0;
                end else begin
                    hsel[k] = 1'b0; htrans[k] = 2'b00;
                end
            end
        end
        chk($sformatf("i%0d_timeout", k), 32'(budget >= c_BUDGET), 32'd0);
        cmd_q.delete();
        sb_q.delete();
        hsel[k] = 1'b0; htrans[k] = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; hsel[i] = 1'b0; haddr[i] = 32'd0; htrans[i] = 2'b00;
            hwrite[i] = 1'b0; hsize[i] = 3'b010; hwdata[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d_rst_hreadyout", i), {31'd0, hreadyout[i]}, 32'd1);
            chk($sformatf("i%0d_rst_hresp", i), {31'd0, hresp[i]}, 32'd0);
            chk($sformatf("i%0d_rst_hrdata", i), hrdata[i], 32'd0);
        end
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

        // WAIT_STATES=1: write/read, error cases, non-transfers, RAW
        add(1, 2'b10, 1, 32'h08, 3'b010, 32'hDEADBEEF);
        add(1, 2'b10, 0, 32'h08, 3'b010, 32'h0);
        add(1, 2'b10, 0, 32'h102, 3'b010, 32'h0);
        add(1, 2'b10, 1, 32'h10, 3'b010, 32'h12345678);
        add(1, 2'b10, 1, 32'h10, 3'b000, 32'h00000BAD);
        add(1, 2'b10, 1, 32'h100, 3'b010, 32'h00000BAD);
        add(1, 2'b10, 0, 32'h10, 3'b010, 32'h0);
        add(1, 2'b10, 1, 32'h18, 3'b010, 32'hCAFEF00D);
        add(1, 2'b01, 1, 32'h18, 3'b010, 32'h0);
        add(0, 2'b10, 1, 32'h18, 3'b010, 32'h0);
        add(1, 2'b10, 0, 32'h18, 3'b010, 32'h0);
        add(1, 2'b11, 1, 32'h0C, 3'b010, 32'h0BADF00D);
        add(1, 2'b11, 0, 32'h0C, 3'b010, 32'h0);
        run(0);

        // WAIT_STATES=0: zero-wait back-to-back traffic
        add(1, 2'b10, 1, 32'h00, 3'b010, 32'h11);
        add(1, 2'b10, 1, 32'h04, 3'b010, 32'h22);
        add(1, 2'b10, 0, 32'h00, 3'b010, 32'h0);
        add(1, 2'b10, 0, 32'h04, 3'b010, 32'h0);
        add(1, 2'b10, 1, 32'h3C, 3'b010, 32'h77);
        add(1, 2'b10, 0, 32'h3C, 3'b010, 32'h0);
        add(1, 2'b10, 0, 32'h102, 3'b010, 32'h0);
        add(1, 2'b10, 0, 32'h04, 3'b010, 32'h0);
        run(1);

        // WAIT_STATES=3: seed 0x20 and the last word
        add(1, 2'b10, 1, 32'h20, 3'b010, 32'hA5A5A5A5);
        add(1, 2'b10, 1, 32'hFC, 3'b010, 32'h5A5A0FF0);
        add(1, 2'b10, 0, 32'h20, 3'b010, 32'h0);
        add(1, 2'b10, 0, 32'hFC, 3'b010, 32'h0);
        run(2);

        // Reset in the middle of the WAIT of a write: write must not commit
        @(negedge clk);
        hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b1; haddr[2] = 32'h20; hsize[2] = 3'b010;
        @(negedge clk);
        hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 32'h55;
        chk("i2_wait_low", {31'd0, hreadyout[2]}, 32'd0);
        @(negedge clk);
        rstn[2] = 1'b0;
        #1;
        chk("i2_abort_hreadyout", {31'd0, hreadyout[2]}, 32'd1);
        chk("i2_abort_hresp", {31'd0, hresp[2]}, 32'd0);
        chk("i2_abort_hrdata", hrdata[2], 32'd0);
        repeat (2) @(negedge clk);
        rstn[2] = 1'b1;
        add(1, 2'b10, 0, 32'h20, 3'b010, 32'h0);
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
